// File: rtl/jimmy_p.sv
// jimmy_p: small accumulator-style CPU core with a 4-entry register file, flags, data memory and I/O ports
// Ports:
//   jimmy_clk        - sole clock, rising edge
//   reset            - synchronous, active-low
//   inst_data_bus    - program byte at inst_address_bus
//   inst_address_bus - program counter
//   in_port/out_port - NPORT flattened DW-bit ports, port k at [k*DW +: DW]
//   in_strobe        - active-low one-cycle pulse after an INPUT from that port
//   out_strobe       - active-low one-cycle pulse after an OUTPUT to that port
//   halted           - high while the core sits in HALT
// Build option: define JIMMY_STACK_EN to enable PUSH/POP/CALL/RET and the stack pointer;
// without it those opcodes are undefined and halt the core.
module jimmy_p #(
    parameter int DW     = 8,
    parameter int NPORT  = 4,
    parameter int MEM_AW = 8
) (
    input  logic                jimmy_clk,
    input  logic                reset,
    input  logic [7:0]          inst_data_bus,
    output logic [7:0]          inst_address_bus,
    input  logic [NPORT*DW-1:0] in_port,
    output logic [NPORT*DW-1:0] out_port,
    output logic [NPORT-1:0]    in_strobe,
    output logic [NPORT-1:0]    out_strobe,
    output logic                halted
);
    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_MOV = 6'b000100,
        OP_NOP = 6'b000111, OP_LD_IMM = 6'b100000, OP_LD_MEM = 6'b100001, OP_ST_MEM = 6'b100010,
        OP_CMP = 6'b100011, OP_DEC = 6'b100101, OP_INPUT = 6'b100110, OP_OUTPUT = 6'b100111,
        OP_BRA = 6'b101010, OP_BHI = 6'b101100, OP_BEQ = 6'b101101, OP_PUSH = 6'b110001,
        OP_POP = 6'b110010, OP_CALL = 6'b110011, OP_RET = 6'b110100;

    typedef enum logic [1:0] {FETCH, EXECUTE, WRITE_BACK, HALT} state_t;

    // Short opcodes are zero-padded so both encodings share one 6-bit space without overlap.
    function automatic logic [5:0] decode(input logic [7:0] b);
        return b[7] ? b[7:2] : {2'b00, b[7:4]};
    endfunction

    function automatic logic known(input logic [5:0] op);
        logic k;
        k = op inside {OP_ADD, OP_SUB, OP_MOV, OP_NOP, OP_LD_IMM, OP_LD_MEM, OP_ST_MEM, OP_CMP,
                       OP_DEC, OP_INPUT, OP_OUTPUT, OP_BRA, OP_BHI, OP_BEQ};
`ifdef JIMMY_STACK_EN
        k = k | (op inside {OP_PUSH, OP_POP, OP_CALL, OP_RET});
`endif
        return k;
    endfunction

    state_t              r_state;
    logic [7:0]          r_pc, r_ir, r_imm;
    logic [DW-1:0]       r_reg [4];
    logic [DW-1:0]       r_mem [2**MEM_AW];
    logic                r_z, r_n, r_c, r_v, r_halted;
    logic [NPORT*DW-1:0] r_out_port;
    logic [NPORT-1:0]    r_in_strobe, r_out_strobe;
`ifdef JIMMY_STACK_EN
    logic [MEM_AW-1:0]   r_sp;
`endif

    logic [5:0]        w_op;
    logic [1:0]        w_ra, w_rb;
    logic [DW-1:0]     w_a, w_b, w_opd, w_res, w_ld, w_stk, w_wd;
    logic [DW:0]       w_sum;
    logic [MEM_AW-1:0] w_addr, w_wa;
    logic              w_ovf, w_taken, w_we;
    logic [DW-1:0]     w_in [4];

    assign inst_address_bus = r_pc;
    assign out_port         = r_out_port;
    assign in_strobe        = r_in_strobe;
    assign out_strobe       = r_out_strobe;
    assign halted           = r_halted;

    assign w_op   = decode(r_ir);
    assign w_ra   = r_ir[7] ? r_ir[1:0] : r_ir[3:2];
    assign w_rb   = r_ir[1:0];
    assign w_a    = r_reg[w_ra];
    assign w_b    = r_reg[w_rb];
    assign w_addr = inst_data_bus[MEM_AW-1:0];

    // Ports beyond NPORT read as zero so INPUT from them loads 0.
    for (genvar k = 0; k < 4; k++) begin : g_in
        if (k < NPORT) begin : g_on
            assign w_in[k] = in_port[k*DW +: DW];
        end else begin : g_off
            assign w_in[k] = '0;
        end
    end

`ifdef JIMMY_STACK_EN
    assign w_stk = r_mem[r_sp];
`else
    assign w_stk = '0;
`endif

    // Value for the flag-setting loads; POP is the fall-through case.
    assign w_ld = (w_op == OP_MOV)    ? w_b :
                  (w_op == OP_LD_IMM) ? DW'(inst_data_bus) :
                  (w_op == OP_LD_MEM) ? r_mem[w_addr] : w_stk;

    // Subtraction in DW+1 bits leaves the borrow in the top bit, matching unsigned A<B.
    assign w_opd = (w_op == OP_ADD || w_op == OP_SUB) ? w_b : (w_op == OP_CMP) ? DW'(r_imm) : DW'(1);
    assign w_sum = (w_op == OP_ADD) ? {1'b0, w_a} + {1'b0, w_opd} : {1'b0, w_a} - {1'b0, w_opd};
    assign w_res = w_sum[DW-1:0];
    assign w_ovf = (w_op == OP_ADD) ? (w_a[DW-1] == w_opd[DW-1]) && (w_res[DW-1] != w_a[DW-1])
                                    : (w_a[DW-1] != w_opd[DW-1]) && (w_res[DW-1] != w_a[DW-1]);

    assign w_taken = (w_op == OP_BRA) || (w_op == OP_BHI && !r_c && !r_z) || (w_op == OP_BEQ && r_z);

    always_comb begin
        w_we = 1'b0;
        w_wa = w_addr;
        w_wd = w_a;
        if (reset && r_state == EXECUTE) begin
            w_we = (w_op == OP_ST_MEM);
`ifdef JIMMY_STACK_EN
            if (w_op == OP_PUSH || w_op == OP_CALL) begin
                w_we = 1'b1;
                w_wa = r_sp;
                w_wd = (w_op == OP_CALL) ? DW'(r_pc + 8'd1) : w_a;
            end
`endif
        end
    end

    always_ff @(posedge jimmy_clk)
        if (w_we) r_mem[w_wa] <= w_wd;

    always_ff @(posedge jimmy_clk) begin
        if (!reset) begin
            r_state      <= FETCH;
            r_pc         <= '0;
            r_ir         <= '0;
            r_imm        <= '0;
            {r_z, r_n, r_c, r_v} <= '0;
            r_halted     <= 1'b0;
            r_out_port   <= '0;
            r_in_strobe  <= '1;
            r_out_strobe <= '1;
            for (int i = 0; i < 4; i++) r_reg[i] <= '0;
`ifdef JIMMY_STACK_EN
            r_sp         <= '1;
`endif
        end else begin
            r_in_strobe  <= '1;
            r_out_strobe <= '1;
            case (r_state)
                FETCH: begin
                    r_ir <= inst_data_bus;
                    if (known(decode(inst_data_bus))) begin
                        r_pc    <= r_pc + 8'd1;
                        r_state <= EXECUTE;
                    end else begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                end
                EXECUTE: begin
                    // inst_data_bus now holds the immediate byte for two-byte ops.
                    r_imm   <= inst_data_bus;
                    r_state <= (w_op inside {OP_ADD, OP_SUB, OP_CMP, OP_DEC, OP_INPUT, OP_OUTPUT, OP_POP, OP_RET})
                               ? WRITE_BACK : FETCH;
                    if (w_op inside {OP_LD_IMM, OP_LD_MEM, OP_ST_MEM, OP_CMP, OP_BRA, OP_BHI, OP_BEQ, OP_CALL})
                        r_pc <= r_pc + 8'd1;
                    if (w_taken) r_pc <= inst_data_bus;
                    if (w_op inside {OP_MOV, OP_LD_IMM, OP_LD_MEM}) begin
                        r_reg[w_ra] <= w_ld;
                        r_z <= (w_ld == '0);
                        r_n <= w_ld[DW-1];
                        r_v <= 1'b0;
                    end
`ifdef JIMMY_STACK_EN
                    if (w_op == OP_PUSH || w_op == OP_CALL) r_sp <= r_sp - 1'b1;
                    if (w_op == OP_CALL) r_pc <= inst_data_bus;
                    if (w_op == OP_POP || w_op == OP_RET) r_sp <= r_sp + 1'b1;
`endif
                end
                WRITE_BACK: begin
                    r_state <= FETCH;
                    if (w_op inside {OP_ADD, OP_SUB, OP_CMP, OP_DEC}) begin
                        if (w_op != OP_CMP) r_reg[w_ra] <= w_res;
                        r_z <= (w_res == '0);
                        r_n <= w_res[DW-1];
                        r_v <= w_ovf;
                        if (w_op != OP_DEC) r_c <= w_sum[DW];
                    end
                    if (w_op == OP_INPUT) begin
                        r_reg[w_ra] <= w_in[w_ra];
                        for (int k = 0; k < NPORT; k++)
                            if (w_ra == 2'(k)) r_in_strobe[k] <= 1'b0;
                    end
                    if (w_op == OP_OUTPUT)
                        for (int k = 0; k < NPORT; k++)
                            if (w_ra == 2'(k)) begin
                                r_out_port[k*DW +: DW] <= w_a;
                                r_out_strobe[k]        <= 1'b0;
                            end
`ifdef JIMMY_STACK_EN
                    // sp was already advanced in EXECUTE, so it points at the popped word.
                    if (w_op == OP_POP) begin
                        r_reg[w_ra] <= w_ld;
                        r_z <= (w_ld == '0);
                        r_n <= w_ld[DW-1];
                        r_v <= 1'b0;
                    end
                    if (w_op == OP_RET) r_pc <= w_stk[7:0];
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/jimmy_p.md
JIMMY_P -- requirements
Module: jimmy_p

Interface
REQ-001 Parameter DW, default 8, register/data-memory/port data width in bits (8..32).
REQ-002 Parameter NPORT, default 4, number of I/O ports (1..4).
REQ-003 Parameter MEM_AW, default 8, data-memory address width (4..8), depth 2^MEM_AW words of DW bits.
REQ-004 jimmy_clk  in  1  sole clock, all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 inst_data_bus  in  8  program-memory read data for inst_address_bus.
REQ-007 inst_address_bus  out  8  equals pc at all times.
REQ-008 in_port  in  NPORT*DW  flattened input ports, port k at bits [k*DW+DW-1 : k*DW].
REQ-009 out_port  out  NPORT*DW  flattened output port registers, same packing.
REQ-010 in_strobe  out  NPORT  active-low read strobe per port.
REQ-011 out_strobe  out  NPORT  active-low write strobe per port.
REQ-012 halted  out  1  high while core is in HALT state.

Function
REQ-013 Core SHALL hold 4 DW-bit registers r0..r3, flags Z,N,C,V, 8-bit pc, MEM_AW-bit sp, and states FETCH, EXECUTE, WRITE_BACK, HALT.
REQ-014 Decode: bit7=0 -> opcode [7:4], ra [3:2], rb [1:0]; bit7=1 -> opcode [7:2], ra [1:0].
REQ-015 Single-byte ops: ADD 0000, SUB 0001, MOV 0100, NOP 0111, DEC 100101, INPUT 100110, OUTPUT 100111, PUSH 110001, POP 110010, RET 110100.
REQ-016 Two-byte ops (immediate byte imm at pc+1, pc incremented in FETCH): LD_IMM 100000, LD_MEM 100001, ST_MEM 100010, CMP 100011, BRA 101010, BHI 101100, BEQ 101101, CALL 110011.
REQ-017 Latency: MOV, NOP, LD_IMM, LD_MEM, ST_MEM, branches, PUSH, CALL SHALL take 2 cycles (FETCH, EXECUTE); ADD, SUB, CMP, DEC, INPUT, OUTPUT, POP, RET SHALL take 3 cycles (FETCH, EXECUTE, WRITE_BACK).
REQ-018 Arithmetic SHALL be modulo 2^DW; LD_IMM zero-extends imm to DW; memory address = imm[MEM_AW-1:0].
REQ-019 ADD: C = carry-out; SUB/CMP/DEC: C = borrow (unsigned A<B); V = signed overflow; N = msb; Z = result==0; CMP writes flags only; DEC leaves C unchanged.
REQ-020 MOV, LD_IMM, LD_MEM, POP SHALL set Z/N from loaded value, clear V, keep C.
REQ-021 BHI taken iff C==0 and Z==0; BEQ taken iff Z==1; taken -> pc<=imm, else pc<=pc+1.
REQ-022 INPUT: r[ra]<=port ra; OUTPUT: out_port ra<=r[ra]; matching strobe bit SHALL be 0 for exactly the one cycle following WRITE_BACK, 1 otherwise.
REQ-023 ra>=NPORT on INPUT/OUTPUT: INPUT loads 0, OUTPUT writes nothing, no strobe pulse.
REQ-024 PUSH: mem[sp]<=r[ra], sp<=sp-1; POP: sp<=sp+1 in EXECUTE, r[ra]<=mem[sp] in WRITE_BACK.
REQ-025 CALL: mem[sp]<=pc+1 (return address, zero-extended), sp<=sp-1, pc<=imm; RET: pc<=mem[sp+1][7:0], sp<=sp+1.
REQ-026 sp SHALL wrap modulo 2^MEM_AW silently on overflow/underflow.
REQ-027 pc SHALL wrap 0xFF->0x00.
REQ-028 Any undefined opcode SHALL enter HALT: pc frozen, strobes 1, halted=1 until reset.

Reset
REQ-029 reset==0 at a clock edge SHALL force state FETCH, pc=0, sp=all ones, in_strobe/out_strobe all ones, halted=0, out_port all zeros, flags 0, regardless of current state (including mid-instruction or HALT).
REQ-030 Registers r0..r3 SHALL reset to 0; data memory SHALL NOT be reset.

Configuration
REQ-031 Macro JIMMY_STACK_EN: defined -> PUSH, POP, CALL, RET implemented per REQ-024..026; undefined -> those four opcodes SHALL be undefined and enter HALT (REQ-028), sp logic removed.

Verification
REQ-032 DW=8: LD_IMM r0,0xF0; LD_IMM r1,0x20; ADD r0,r1 -> r0=0x10, C=1, Z=0, V=0, ADD completes in 3 cycles.
REQ-033 LD_IMM r2,5; CMP r2,5; BEQ 0x40 -> pc=0x40; CMP r2,6; BHI 0x40 -> not taken, pc advances by 2.
REQ-034 in_port port1=0xA5; INPUT r1; OUTPUT r1 on port1 -> r1=0xA5, out_port port1=0xA5, in_strobe[1] then out_strobe[1] each low exactly 1 cycle.
REQ-035 JIMMY_STACK_EN defined: r3=0x77; PUSH r3; CALL 0x20; at 0x20 RET; POP r0 -> r0=0x77, sp=0xFF, pc resumes after CALL; undefined macro: PUSH -> halted=1, pc frozen.
REQ-036 Opcode 0xFC fetched -> halted=1; assert reset low one cycle mid-HALT and mid-ADD -> pc=0, state FETCH, strobes 1, halted=0 next cycle.
